// File: rtl/game_tick_sequencer.sv
// game_tick_sequencer
//
// Schedules the work for one game tick as an ordered stream of commands to
// the object-update datapath. The order is: fire a player bullet, spawn an
// enemy tank, move every live bullet, then move every live enemy tank. This
// block owns the live-object counts and the swap-with-last delete
// bookkeeping, so the updater only ever executes one command at a time.
//
// Ports
//   clk_100mhz  system clock; every flop updates on its rising edge
//   rst_n       asynchronous active-low reset
//   tick        one-cycle game-tick strobe
//   shoot_req   one-cycle player fire strobe; latched until served
//   spawn_req   one-cycle enemy spawn strobe; latched until served
//   cmd_valid   a command is presented; held until cmd_done
//   cmd_op      0 MOVE_BULLET, 1 MOVE_TANK, 2 SPAWN_TANK, 3 FIRE
//   cmd_slot    target slot of the command
//   cmd_last    last live slot of the addressed table (swap source on delete)
//   cmd_done    updater completion, only honoured while cmd_valid=1
//   cmd_kill    with cmd_done: delete (MOVE ops) or rejected (SPAWN/FIRE)
//   n_bullets   live bullet count
//   n_tanks     live tank count, player included
//   busy        a tick sequence is in progress
//   tick_done   one-cycle pulse when the tick sequence has finished
//   overrun     sticky: a tick arrived that could not be accepted
//   game_over   sticky: a kill was reported against the player tank
module game_tick_sequencer #(
    parameter int MAX_TANKS   = 10,
    parameter int MAX_BULLETS = 10
) (
    input  logic       clk_100mhz,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       shoot_req,
    input  logic       spawn_req,
    output logic       cmd_valid,
    output logic [1:0] cmd_op,
    output logic [6:0] cmd_slot,
    output logic [6:0] cmd_last,
    input  logic       cmd_done,
    input  logic       cmd_kill,
    output logic [6:0] n_bullets,
    output logic [5:0] n_tanks,
    output logic       busy,
    output logic       tick_done,
    output logic       overrun,
    output logic       game_over
);

    localparam logic [1:0] OP_MOVE_BULLET = 2'd0;
    localparam logic [1:0] OP_MOVE_TANK   = 2'd1;
    localparam logic [1:0] OP_SPAWN_TANK  = 2'd2;
    localparam logic [1:0] OP_FIRE        = 2'd3;

    localparam logic [6:0] MAX_B = 7'(MAX_BULLETS);
    localparam logic [5:0] MAX_T = 6'(MAX_TANKS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FIRE,
        S_SPAWN,
        S_BWALK,
        S_TWALK,
        S_NEXT
    } state_t;

    // Phase ordering matters: NEXT picks the first applicable phase at or
    // after the current one, so the enum values must follow the tick order.
    typedef enum logic [1:0] {
        PH_FIRE,
        PH_SPAWN,
        PH_BWALK,
        PH_TWALK
    } phase_t;

    state_t     state_q, state_d;
    phase_t     phase_q, phase_d;
    logic [6:0] ptr_q, ptr_d;
    logic [6:0] n_bullets_q, n_bullets_d;
    logic [5:0] n_tanks_q, n_tanks_d;
    logic       shoot_pend_q, shoot_pend_d;
    logic       spawn_pend_q, spawn_pend_d;
    logic       tick_done_q, tick_done_d;
    logic       overrun_q, overrun_d;
    logic       game_over_q, game_over_d;
    logic [1:0] cmd_op_q, cmd_op_d;
    logic [6:0] cmd_slot_q, cmd_slot_d;
    logic [6:0] cmd_last_q, cmd_last_d;

    logic       shoot_clr;
    logic       spawn_clr;
    logic       b_full;
    logic       t_full;
    logic [6:0] bptr;
    logic [6:0] tptr;

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            phase_q      <= PH_FIRE;
            ptr_q        <= 7'd0;
            n_bullets_q  <= 7'd0;
            n_tanks_q    <= 6'd1;
            shoot_pend_q <= 1'b0;
            spawn_pend_q <= 1'b0;
            tick_done_q  <= 1'b0;
            overrun_q    <= 1'b0;
            game_over_q  <= 1'b0;
            cmd_op_q     <= 2'd0;
            cmd_slot_q   <= 7'd0;
            cmd_last_q   <= 7'd0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            ptr_q        <= ptr_d;
            n_bullets_q  <= n_bullets_d;
            n_tanks_q    <= n_tanks_d;
            shoot_pend_q <= shoot_pend_d;
            spawn_pend_q <= spawn_pend_d;
            tick_done_q  <= tick_done_d;
            overrun_q    <= overrun_d;
            game_over_q  <= game_over_d;
            cmd_op_q     <= cmd_op_d;
            cmd_slot_q   <= cmd_slot_d;
            cmd_last_q   <= cmd_last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        ptr_d       = ptr_q;
        n_bullets_d = n_bullets_q;
        n_tanks_d   = n_tanks_q;
        tick_done_d = 1'b0;
        game_over_d = game_over_q;
        cmd_op_d    = cmd_op_q;
        cmd_slot_d  = cmd_slot_q;
        cmd_last_d  = cmd_last_q;
        shoot_clr   = 1'b0;
        spawn_clr   = 1'b0;

        // A tick is only accepted from IDLE, and not in the cycle that the
        // previous sequence reports completion.
        overrun_d = overrun_q | (tick & ((state_q != S_IDLE) | tick_done_q));

        b_full = (n_bullets_q >= MAX_B);
        t_full = (n_tanks_q >= MAX_T);

        // Walk pointers restart whenever their walk is entered fresh; the
        // tank walk skips slot 0 because that is the player.
        bptr = (phase_q == PH_BWALK) ? ptr_q : 7'd0;
        tptr = (phase_q == PH_TWALK) ? ptr_q : 7'd1;

        unique case (state_q)
            S_IDLE: begin
                if (tick && !tick_done_q) begin
                    state_d = S_NEXT;
                    phase_d = PH_FIRE;
                    ptr_d   = 7'd0;
                end
            end

            S_NEXT: begin
                if (phase_q == PH_FIRE && shoot_pend_q && !b_full) begin
                    state_d    = S_FIRE;
                    cmd_op_d   = OP_FIRE;
                    cmd_slot_d = n_bullets_q;
                    cmd_last_d = (n_bullets_q == 7'd0) ? 7'd0 : n_bullets_q - 7'd1;
                    shoot_clr  = 1'b1;
                end else if (phase_q <= PH_SPAWN && spawn_pend_q && !t_full) begin
                    state_d    = S_SPAWN;
                    phase_d    = PH_SPAWN;
                    cmd_op_d   = OP_SPAWN_TANK;
                    cmd_slot_d = {1'b0, n_tanks_q};
                    cmd_last_d = {1'b0, n_tanks_q} - 7'd1;
                    spawn_clr  = 1'b1;
                end else if (phase_q <= PH_BWALK && bptr < n_bullets_q) begin
                    state_d    = S_BWALK;
                    phase_d    = PH_BWALK;
                    ptr_d      = bptr;
                    cmd_op_d   = OP_MOVE_BULLET;
                    cmd_slot_d = bptr;
                    cmd_last_d = n_bullets_q - 7'd1;
                end else if (tptr < {1'b0, n_tanks_q}) begin
                    state_d    = S_TWALK;
                    phase_d    = PH_TWALK;
                    ptr_d      = tptr;
                    cmd_op_d   = OP_MOVE_TANK;
                    cmd_slot_d = tptr;
                    cmd_last_d = {1'b0, n_tanks_q} - 7'd1;
                end else begin
                    state_d     = S_IDLE;
                    tick_done_d = 1'b1;
                end

                // Requests against a full table are dropped rather than
                // carried into later ticks. The tank count cannot change
                // while a FIRE is outstanding, so dropping a spawn early is
                // equivalent to dropping it when its phase comes up.
                if (phase_q == PH_FIRE && b_full) begin
                    shoot_clr = 1'b1;
                end
                if (phase_q <= PH_SPAWN && t_full) begin
                    spawn_clr = 1'b1;
                end
            end

            S_FIRE: begin
                if (cmd_done) begin
                    if (!cmd_kill && n_bullets_q < MAX_B) begin
                        n_bullets_d = n_bullets_q + 7'd1;
                    end
                    phase_d = PH_SPAWN;
                    state_d = S_NEXT;
                end
            end

            S_SPAWN: begin
                if (cmd_done) begin
                    if (!cmd_kill && n_tanks_q < MAX_T) begin
                        n_tanks_d = n_tanks_q + 6'd1;
                    end
                    phase_d = PH_BWALK;
                    ptr_d   = 7'd0;
                    state_d = S_NEXT;
                end
            end

            // On a delete the last object is swapped into this slot, so the
            // pointer stays put to visit it. The walk ends naturally once
            // the pointer reaches the shrunken count.
            S_BWALK: begin
                if (cmd_done) begin
                    if (cmd_kill) begin
                        if (n_bullets_q != 7'd0) begin
                            n_bullets_d = n_bullets_q - 7'd1;
                        end
                    end else begin
                        ptr_d = ptr_q + 7'd1;
                    end
                    state_d = S_NEXT;
                end
            end

            // A kill against slot 0 is the player dying: flag it and keep the
            // player in the table instead of deleting it.
            S_TWALK: begin
                if (cmd_done) begin
                    if (cmd_kill) begin
                        if (cmd_slot_q == 7'd0) begin
                            game_over_d = 1'b1;
                        end else if (n_tanks_q > 6'd1) begin
                            n_tanks_d = n_tanks_q - 6'd1;
                        end
                    end else begin
                        ptr_d = ptr_q + 7'd1;
                    end
                    state_d = S_NEXT;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A fresh strobe in the same cycle as a clear wins, so no request
        // is lost.
        shoot_pend_d = shoot_req | (shoot_pend_q & ~shoot_clr);
        spawn_pend_d = spawn_req | (spawn_pend_q & ~spawn_clr);
    end

    assign cmd_valid = (state_q == S_FIRE) || (state_q == S_SPAWN) ||
                       (state_q == S_BWALK) || (state_q == S_TWALK);
    assign cmd_op    = cmd_op_q;
    assign cmd_slot  = cmd_slot_q;
    assign cmd_last  = cmd_last_q;
    assign n_bullets = n_bullets_q;
    assign n_tanks   = n_tanks_q;
    assign busy      = (state_q != S_IDLE);
    assign tick_done = tick_done_q;
    assign overrun   = overrun_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_game_tick_sequencer.sv
// tb_game_tick_sequencer
//
// Scoreboard bench for game_tick_sequencer. A behavioural model computes the
// whole command list of a tick from the live counts, the pending requests and
// a pre-drawn list of kill decisions. It pushes the expected commands and
// end-of-tick counts into queues. A responder process acts as the updater,
// and a monitor process pops and compares whatever the DUT presents.
`timescale 1ns/1ps
module tb_game_tick_sequencer;

    localparam int MAXT = 10;
    localparam int MAXB = 10;

    logic       clk_100mhz = 1'b0;
    logic       rst_n      = 1'b1;
    logic       tick       = 1'b0;
    logic       shoot_req  = 1'b0;
    logic       spawn_req  = 1'b0;
    logic       cmd_done   = 1'b0;
    logic       cmd_kill   = 1'b0;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic [6:0] cmd_slot;
    logic [6:0] cmd_last;
    logic [6:0] n_bullets;
    logic [5:0] n_tanks;
    logic       busy;
    logic       tick_done;
    logic       overrun;
    logic       game_over;

    int testsRun    = 0;
    int testsFailed = 0;

    // A negative last means the field is not meaningful for that op.
    typedef struct {
        int op;
        int slot;
        int last;
    } cmd_t;

    cmd_t expQ[$];
    bit   killQ[$];
    int   endNbQ[$];
    int   endNtQ[$];

    int mNb     = 0;
    int mNt     = 1;
    bit mShoot  = 0;
    bit mSpawn  = 0;

    int fixedLat       = -1;
    int moveBulletSeen = 0;
    int fireSeen       = 0;

    game_tick_sequencer #(
        .MAX_TANKS   (MAXT),
        .MAX_BULLETS (MAXB)
    ) dut (
        .clk_100mhz (clk_100mhz),
        .rst_n      (rst_n),
        .tick       (tick),
        .shoot_req  (shoot_req),
        .spawn_req  (spawn_req),
        .cmd_valid  (cmd_valid),
        .cmd_op     (cmd_op),
        .cmd_slot   (cmd_slot),
        .cmd_last   (cmd_last),
        .cmd_done   (cmd_done),
        .cmd_kill   (cmd_kill),
        .n_bullets  (n_bullets),
        .n_tanks    (n_tanks),
        .busy       (busy),
        .tick_done  (tick_done),
        .overrun    (overrun),
        .game_over  (game_over)
    );

    // 100 MHz clock.
    always #5 clk_100mhz = ~clk_100mhz;

    // Keeps the run bounded even if the DUT wedges somewhere unexpected.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: run still active at time limit, expected summary earlier");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point so every check is counted the same way.
    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic reportFail(input string name, input string detail);
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL %s: %s", name, detail);
    endtask

    // Kill decision for the idx-th command of a tick: either a fixed mask
    // for directed cases or a random draw.
    function automatic bit decide(input int killPct, input bit useMask,
                                  input bit [31:0] mask, input int idx);
        if (useMask) begin
            return (idx < 32) ? mask[idx] : 1'b0;
        end
        return (int'($urandom_range(0, 99)) < killPct);
    endfunction

    task automatic pushCmd(input int op, input int slot, input int last, input bit k);
        cmd_t c;
        c.op   = op;
        c.slot = slot;
        c.last = last;
        expQ.push_back(c);
        killQ.push_back(k);
    endtask

    // Reference model of one tick, written as plain list processing over
    // the object tables: optional fire, optional spawn, then a walk over each
    // table where a delete shrinks the table and revisits the same index.
    task automatic modelTick(input int killPct, input bit useMask, input bit [31:0] mask);
        int idx = 0;
        int i;
        bit k;
        if (mShoot) begin
            if (mNb < MAXB) begin
                k = decide(killPct, useMask, mask, idx++);
                pushCmd(3, mNb, -1, k);
                if (!k) mNb++;
            end
            mShoot = 0;
        end
        if (mSpawn) begin
            if (mNt < MAXT) begin
                k = decide(killPct, useMask, mask, idx++);
                pushCmd(2, mNt, -1, k);
                if (!k) mNt++;
            end
            mSpawn = 0;
        end
        i = 0;
        while (i < mNb) begin
            k = decide(killPct, useMask, mask, idx++);
            pushCmd(0, i, mNb - 1, k);
            if (k) mNb--;
            else   i++;
        end
        i = 1;
        while (i < mNt) begin
            k = decide(killPct, useMask, mask, idx++);
            pushCmd(1, i, mNt - 1, k);
            if (k) mNt--;
            else   i++;
        end
        endNbQ.push_back(mNb);
        endNtQ.push_back(mNt);
    endtask

    // Updater stand-in: acknowledges each presented command after a fixed
    // or random delay, using the kill decisions in issue order.
    initial begin : responder
        int lat;
        forever begin
            @(negedge clk_100mhz);
            if (cmd_valid && rst_n) begin
                lat = (fixedLat >= 0) ? fixedLat : int'($urandom_range(0, 3));
                repeat (lat) @(negedge clk_100mhz);
                cmd_kill = (killQ.size() > 0) ? killQ.pop_front() : 1'b0;
                cmd_done = 1'b1;
                @(negedge clk_100mhz);
                cmd_done = 1'b0;
                cmd_kill = 1'b0;
            end
        end
    end

    // Monitor: every new command is compared with the head of the expected
    // queue, and every tick_done with the expected end-of-tick counts.
    initial begin : monitor
        bit   prevValid;
        cmd_t e;
        prevValid = 0;
        forever begin
            @(negedge clk_100mhz);
            if (!rst_n) begin
                prevValid = 0;
            end else begin
                if (cmd_valid && !prevValid) begin
                    if (cmd_op == 2'd0) moveBulletSeen++;
                    if (cmd_op == 2'd3) fireSeen++;
                    if (expQ.size() == 0) begin
                        reportFail("unexpectedCmd", $sformatf("got op %0d slot %0d, expected no command", cmd_op, cmd_slot));
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("cmdOp", int'(cmd_op), e.op);
                        checkOutput("cmdSlot", int'(cmd_slot), e.slot);
                        if (e.last >= 0) checkOutput("cmdLast", int'(cmd_last), e.last);
                    end
                end
                prevValid = cmd_valid;
                if (tick_done) begin
                    if (endNbQ.size() == 0) begin
                        reportFail("unexpectedTickDone", "got tick_done, expected none");
                    end else begin
                        checkOutput("endBullets", int'(n_bullets), endNbQ.pop_front());
                        checkOutput("endTanks", int'(n_tanks), endNtQ.pop_front());
                    end
                end
            end
        end
    end

    // Pulses the player/spawn strobes while the sequencer is idle.
    task automatic applyStimulus(input bit doShoot, input bit doSpawn);
        shoot_req = doShoot;
        spawn_req = doSpawn;
        if (doShoot) mShoot = 1;
        if (doSpawn) mSpawn = 1;
        @(negedge clk_100mhz);
        shoot_req = 1'b0;
        spawn_req = 1'b0;
    endtask

    // Runs one full tick from a negedge while idle. Optionally drives a
    // second tick while busy, or a tick in the tick_done cycle.
    task automatic runTick(input int killPct, input bit useMask, input bit [31:0] mask,
                           input int extraTickAt, input bit tickOnDone,
                           output int doneCyc, output int firstValid);
        int cyc;
        modelTick(killPct, useMask, mask);
        firstValid = -1;
        tick = 1'b1;
        @(negedge clk_100mhz);
        cyc  = 1;
        tick = (extraTickAt == 1);
        checkOutput("busyAfterTick", int'(busy), 1);
        while (!tick_done && cyc < 3000) begin
            if (cmd_valid && firstValid < 0) firstValid = cyc;
            @(negedge clk_100mhz);
            cyc++;
            tick = (cyc == extraTickAt) && !tick_done;
        end
        doneCyc = cyc;
        if (!tick_done) begin
            reportFail("tickDoneTimeout", $sformatf("got no tick_done in %0d cycles, expected one", cyc));
        end else begin
            checkOutput("busyAtTickDone", int'(busy), 0);
        end
        tick = tickOnDone;
        @(negedge clk_100mhz);
        tick = 1'b0;
    endtask

    task automatic startReset();
        rst_n     = 1'b0;
        tick      = 1'b0;
        shoot_req = 1'b0;
        spawn_req = 1'b0;
    endtask

    // Holds reset long enough for the responder to finish any handshake it
    // was in, then discards everything expected from the aborted sequence.
    task automatic endReset();
        repeat (6) @(negedge clk_100mhz);
        expQ.delete();
        killQ.delete();
        endNbQ.delete();
        endNtQ.delete();
        mNb    = 0;
        mNt    = 1;
        mShoot = 0;
        mSpawn = 0;
        rst_n  = 1'b1;
        @(negedge clk_100mhz);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "CmdValid"}, int'(cmd_valid), 0);
        checkOutput({tag, "CmdOp"}, int'(cmd_op), 0);
        checkOutput({tag, "CmdSlot"}, int'(cmd_slot), 0);
        checkOutput({tag, "CmdLast"}, int'(cmd_last), 0);
        checkOutput({tag, "NBullets"}, int'(n_bullets), 0);
        checkOutput({tag, "NTanks"}, int'(n_tanks), 1);
        checkOutput({tag, "Busy"}, int'(busy), 0);
        checkOutput({tag, "TickDone"}, int'(tick_done), 0);
        checkOutput({tag, "Overrun"}, int'(overrun), 0);
        checkOutput({tag, "GameOver"}, int'(game_over), 0);
    endtask

    initial begin : main
        int  doneCyc;
        int  firstValid;
        int  waitCyc;

        $display("[TB] game_tick_sequencer bench starting");
        @(negedge clk_100mhz);
        startReset();
        #1;
        checkResetValues("reset");
        @(negedge clk_100mhz);
        endReset();

        // Empty tick: no commands, done two cycles after the tick.
        runTick(0, 0, 0, 0, 0, doneCyc, firstValid);
        checkOutput("emptyTickDoneLatency", doneCyc, 2);
        checkOutput("emptyTickNoCmd", firstValid, -1);
        checkOutput("emptyTickTanks", int'(n_tanks), 1);

        // Fire + spawn with a three-cycle updater.
        fixedLat = 3;
        applyStimulus(1, 1);
        runTick(0, 0, 0, 0, 0, doneCyc, firstValid);
        checkOutput("firstCmdLatency", firstValid, 2);
        checkOutput("fireSpawnBullets", int'(n_bullets), 1);
        checkOutput("fireSpawnTanks", int'(n_tanks), 2);
        fixedLat = -1;

        // Three bullets, delete on slot 0 during the walk.
        @(negedge clk_100mhz);
        startReset();
        endReset();
        repeat (3) begin
            applyStimulus(1, 0);
            runTick(0, 0, 0, 0, 0, doneCyc, firstValid);
        end
        moveBulletSeen = 0;
        runTick(0, 1, 32'h1, 0, 0, doneCyc, firstValid);
        checkOutput("killWalkMoveBullets", moveBulletSeen, 3);
        checkOutput("killWalkBullets", int'(n_bullets), 2);

        // Fill the bullet table, then a fire request must be dropped.
        while (mNb < MAXB) begin
            applyStimulus(1, 0);
            runTick(0, 0, 0, 0, 0, doneCyc, firstValid);
        end
        checkOutput("fullTableBullets", int'(n_bullets), MAXB);
        fireSeen = 0;
        applyStimulus(1, 0);
        runTick(0, 0, 0, 0, 0, doneCyc, firstValid);
        runTick(0, 0, 0, 0, 0, doneCyc, firstValid);
        checkOutput("fullTableFires", fireSeen, 0);

        // Tick while busy: sticky overrun, sequence unaffected.
        checkOutput("overrunBefore", int'(overrun), 0);
        runTick(0, 0, 0, 4, 0, doneCyc, firstValid);
        checkOutput("overrunSet", int'(overrun), 1);
        applyStimulus(0, 1);
        runTick(25, 0, 0, 0, 0, doneCyc, firstValid);
        checkOutput("overrunSticky", int'(overrun), 1);

        // Tick coinciding with tick_done is ignored and flagged.
        @(negedge clk_100mhz);
        startReset();
        endReset();
        runTick(0, 0, 0, 0, 1, doneCyc, firstValid);
        checkOutput("tickOnDoneOverrun", int'(overrun), 1);
        checkOutput("tickOnDoneIgnored", int'(busy), 0);

        // Randomised traffic with random kills and updater latency.
        for (int n = 0; n < 25; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            runTick(25, 0, 0, 0, 0, doneCyc, firstValid);
        end

        // Reset while a tank move is outstanding.
        @(negedge clk_100mhz);
        startReset();
        endReset();
        repeat (3) begin
            applyStimulus(0, 1);
            runTick(0, 0, 0, 0, 0, doneCyc, firstValid);
        end
        modelTick(0, 0, 0);
        tick = 1'b1;
        @(negedge clk_100mhz);
        tick = 1'b0;
        waitCyc = 0;
        while (!(cmd_valid && cmd_op == 2'd1) && waitCyc < 500) begin
            @(negedge clk_100mhz);
            waitCyc++;
        end
        if (waitCyc >= 500) begin
            reportFail("twalkTimeout", "got no MOVE_TANK command, expected one");
        end
        #2;
        startReset();
        #1;
        checkResetValues("asyncReset");
        @(negedge clk_100mhz);
        endReset();
        applyStimulus(1, 0);
        runTick(0, 0, 0, 0, 0, doneCyc, firstValid);
        checkOutput("postResetBullets", int'(n_bullets), 1);

        checkOutput("expQueueDrained", expQ.size(), 0);
        checkOutput("gameOverClear", int'(game_over), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/game_tick_sequencer.md
# game_tick_sequencer

Per-tick scheduler for the tank-war object tables. On each game tick it issues a single ordered stream of commands to the object-update datapath: fire, spawn, move every live bullet, move every live enemy tank. It owns the live-object counts and the swap-with-last deletion bookkeeping, so the updater only executes one command at a time. It sits between the tick dividers and player-input edge detectors on one side and the object-table update logic on the other.

## Interface

Parameters:
- MAX_TANKS, 10, tank table depth; slot 0 is the player tank.
- MAX_BULLETS, 10, bullet table depth.

Ports:
- clk_100mhz  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- tick  in  1  one-cycle game-tick strobe, synchronous to clk_100mhz.
- shoot_req  in  1  one-cycle player fire strobe.
- spawn_req  in  1  one-cycle enemy spawn strobe.
- cmd_valid  out  1  command present; held until cmd_done.
- cmd_op  out  2  0 MOVE_BULLET, 1 MOVE_TANK, 2 SPAWN_TANK, 3 FIRE.
- cmd_slot  out  7  target slot index.
- cmd_last  out  7  index of the last live slot of the addressed table; this is the swap source for deletion.
- cmd_done  in  1  updater completion; sampled only while cmd_valid=1.
- cmd_kill  in  1  qualifies cmd_done. For MOVE ops it means delete the slot. For SPAWN/FIRE it means rejected.
- n_bullets  out  7  live bullet count.
- n_tanks  out  6  live tank count, including the player.
- busy  out  1  high from the first cycle after tick until the cycle tick_done is asserted.
- tick_done  out  1  one-cycle pulse when a tick's sequence completes.
- overrun  out  1  sticky: a tick arrived while busy=1.
- game_over  out  1  sticky: a kill was reported on tank slot 0.

## Operation

- Pending flags: shoot_req sets shoot_pend and spawn_req sets spawn_pend.
  - Each flag clears when its command is issued, or when it is dropped because the table is full.
  - If a new strobe arrives in the same cycle the flag would clear, the flag stays set.
- FSM states: IDLE, FIRE, SPAWN, BWALK, TWALK, NEXT.
- IDLE: a tick sets busy and enters NEXT with phase=FIRE.
- NEXT: one cycle with cmd_valid=0. It selects the first applicable phase at or after the current phase:
  - FIRE if shoot_pend and n_bullets<MAX_BULLETS. cmd_slot=n_bullets.
  - SPAWN if spawn_pend and n_tanks<MAX_TANKS. cmd_slot=n_tanks.
  - BWALK for each slot ptr in 0..n_bullets-1. cmd_last=n_bullets-1.
  - TWALK for each slot ptr in 1..n_tanks-1. cmd_last=n_tanks-1.
  - If no phase applies: pulse tick_done, clear busy, return to IDLE.
  - A pending flag whose table is full is cleared without issuing a command.
- Command states assert cmd_valid, with cmd_op, cmd_slot and cmd_last stable until cmd_done.
- On cmd_done:
  - FIRE or SPAWN, no kill: the count increments. Phase advances.
  - FIRE or SPAWN, kill: the count is unchanged. Phase advances.
  - MOVE, no kill: ptr increments.
  - MOVE, kill: the count decrements and ptr is held, because the swapped-in object is not yet visited. If ptr==cmd_last, the walk ends.
  - Every cmd_done goes to NEXT.
- Kill on tank slot 0 is never issued by this block, since TWALK starts at slot 1. A game_over report arrives via MOVE_TANK only if the updater targets slot 0; in that case set game_over and do not decrement.
- Width rules: counts saturate within [0, MAX] and [1, MAX_TANKS]. cmd_slot is zero-extended.

## Timing

- Reset values:
  - cmd_valid=0, cmd_op=0, cmd_slot=0, cmd_last=0.
  - n_bullets=0, n_tanks=1.
  - busy=0, tick_done=0, overrun=0, game_over=0.
  - Pending flags cleared, FSM=IDLE.
- Reset asserted mid-sequence aborts immediately to the reset values.
- Tick at cycle T: busy=1 at T+1, NEXT at T+1, first cmd_valid at T+2.
- cmd_done sampled at cycle C: cmd_valid=0 at C+1 (NEXT), next cmd_valid at C+2.
- Count updates are visible at C+1.
- Empty tick (no pending requests, n_bullets=0, n_tanks=1): tick_done at T+2, busy=0 at T+2.
- A tick while busy is ignored and sets overrun. A tick in the same cycle as tick_done is also ignored and sets overrun.
- cmd_done while cmd_valid=0 is ignored.

## Test plan

- Reset then an empty tick: no cmd_valid; tick_done is asserted 2 cycles after tick; n_tanks=1.
- shoot_req and spawn_req, then a tick, with the updater acknowledging after 3 cycles:
  - Commands in order: FIRE slot 0, SPAWN slot 1, MOVE_BULLET slot 0, MOVE_TANK slot 1.
  - Final counts n_bullets=1, n_tanks=2.
- 3 bullets, with a kill on slot 0:
  - Slot 0 is reissued with cmd_last=1, then slot 1 is issued.
  - n_bullets=2; exactly 3 MOVE_BULLET commands.
- Full bullet table (10) with shoot_req: no FIRE is issued and shoot_pend clears. A second tick issues no FIRE.
- A tick while busy: overrun=1 and stays 1 through later ticks; the sequence in progress is unaffected.
- rst_n low while cmd_valid is high during TWALK: all outputs return to reset values asynchronously, and the next tick starts at FIRE.
